// File: rtl/noc_local_ni.sv
// noc_local_ni: processing-element side of a router local port; queues core packets into
// timestamped flits for injection, and checks and unpacks ejected flits for the core.
module noc_local_ni #(
    parameter int         DATASIZE  = 40,
    parameter logic [3:0] NODE_ID   = 4'd10,
    parameter int         TXQ_DEPTH = 4,
    parameter int         TXQ_AW    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tx_req,
    input  logic [3:0]          tx_dst,
    input  logic [21:0]         tx_payload,
    input  logic [1:0]          tx_type,
    output logic                tx_ready,
    output logic [DATASIZE-1:0] L_data_out,
    output logic                L_valid_out,
    input  logic                full,
    input  logic [DATASIZE-1:0] L_data_in,
    input  logic                L_valid_in,
    output logic                rx_valid,
    output logic [3:0]          rx_src,
    output logic [21:0]         rx_payload,
    output logic [1:0]          rx_type,
    output logic [7:0]          rx_latency,
    output logic [15:0]         tx_count,
    output logic [15:0]         rx_count,
    output logic [15:0]         err_count,
    output logic [15:0]         stall_count
);

    localparam logic [TXQ_AW:0] DEPTH = TXQ_DEPTH[TXQ_AW:0];

    typedef enum logic [1:0] {IDLE, SEND, STALL} tx_state_e;

    tx_state_e             tx_state;
    logic [27:0]           txq_q [TXQ_DEPTH];
    logic [TXQ_AW-1:0]     head_q, tail_q;
    logic [TXQ_AW:0]       count_q, count_d;
    logic [7:0]            ts_q;
    logic                  enq, deq;
    logic [27:0]           head;
    logic [DATASIZE-1:0]   l_data_q;
    logic                  l_valid_q;
    logic                  rx_valid_q;
    logic [3:0]            rx_src_q;
    logic [21:0]           rx_payload_q;
    logic [1:0]            rx_type_q;
    logic [7:0]            rx_latency_q;
    logic [15:0]           tx_count_q, rx_count_q, err_count_q, stall_count_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign tx_ready    = count_q != DEPTH;
    assign head        = txq_q[head_q];
    assign L_data_out  = l_data_q;
    assign L_valid_out = l_valid_q;
    assign rx_valid    = rx_valid_q;
    assign rx_src      = rx_src_q;
    assign rx_payload  = rx_payload_q;
    assign rx_type     = rx_type_q;
    assign rx_latency  = rx_latency_q;
    assign tx_count    = tx_count_q;
    assign rx_count    = rx_count_q;
    assign err_count   = err_count_q;
    assign stall_count = stall_count_q;

    // Tx state is a pure function of queue occupancy and router backpressure this cycle
    always_comb begin
        tx_state = (count_q == '0) ? IDLE : (full ? STALL : SEND);
        enq      = tx_req && tx_ready;
        deq      = tx_state == SEND;
        count_d  = count_q + (TXQ_AW+1)'(enq) - (TXQ_AW+1)'(deq);
    end

    // Queue storage needs no reset; only the pointers define which entries are live
    always_ff @(posedge clk) begin
        if (enq) txq_q[tail_q] <= {tx_dst, tx_payload, tx_type};
    end

    // Timestamp, queue pointers, flit injection and tx statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q          <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            l_data_q      <= '0;
            l_valid_q     <= 1'b0;
            tx_count_q    <= '0;
            stall_count_q <= '0;
        end else begin
            ts_q      <= ts_q + 8'd1;
            count_q   <= count_d;
            l_valid_q <= deq;
            if (enq) tail_q <= tail_q + TXQ_AW'(1);
            if (deq) begin
                head_q     <= head_q + TXQ_AW'(1);
                l_data_q   <= {NODE_ID, head[27:24], ts_q, head[23:0]};
                tx_count_q <= sat_inc(tx_count_q);
            end
            if (tx_state == STALL) stall_count_q <= sat_inc(stall_count_q);
        end
    end

    // Ejection: unpack flits addressed here, count and drop the rest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q   <= 1'b0;
            rx_src_q     <= '0;
            rx_payload_q <= '0;
            rx_type_q    <= '0;
            rx_latency_q <= '0;
            rx_count_q   <= '0;
            err_count_q  <= '0;
        end else begin
            rx_valid_q <= L_valid_in && (L_data_in[35:32] == NODE_ID);
            if (L_valid_in && L_data_in[35:32] == NODE_ID) begin
                rx_src_q     <= L_data_in[39:36];
                rx_payload_q <= L_data_in[23:2];
                rx_type_q    <= L_data_in[1:0];
                rx_latency_q <= ts_q - L_data_in[31:24];
                rx_count_q   <= sat_inc(rx_count_q);
            end else if (L_valid_in) begin
                err_count_q  <= sat_inc(err_count_q);
            end
        end
    end

endmodule

// File: tb/tb_noc_local_ni.sv
// tb_noc_local_ni: directed bench with tx/rx scoreboards for the local network interface.
module tb_noc_local_ni;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tx_req = 1'b0;
    logic [3:0]  tx_dst = '0;
    logic [21:0] tx_payload = '0;
    logic [1:0]  tx_type = '0;
    logic        full = 1'b0;
    logic [39:0] L_data_in = '0;
    logic        L_valid_in = 1'b0;
    logic        tx_ready, L_valid_out, rx_valid;
    logic [39:0] L_data_out;
    logic [3:0]  rx_src;
    logic [21:0] rx_payload;
    logic [1:0]  rx_type;
    logic [7:0]  rx_latency;
    logic [15:0] tx_count, rx_count, err_count, stall_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  m_ts = 8'd0;
    logic [27:0] tx_exp [$];
    logic [35:0] rx_exp [$];

    noc_local_ni dut (
        .clk(clk), .rst_n(rst_n), .tx_req(tx_req), .tx_dst(tx_dst),
        .tx_payload(tx_payload), .tx_type(tx_type), .tx_ready(tx_ready),
        .L_data_out(L_data_out), .L_valid_out(L_valid_out), .full(full),
        .L_data_in(L_data_in), .L_valid_in(L_valid_in), .rx_valid(rx_valid),
        .rx_src(rx_src), .rx_payload(rx_payload), .rx_type(rx_type),
        .rx_latency(rx_latency), .tx_count(tx_count), .rx_count(rx_count),
        .err_count(err_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Reference timestamp counter
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_ts <= 8'd0;
        else m_ts <= m_ts + 8'd1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_tx(input logic [3:0] d, input logic [21:0] p, input logic [1:0] t);
        tx_req = 1'b1;
        tx_dst = d;
        tx_payload = p;
        tx_type = t;
        if (tx_ready) tx_exp.push_back({d, p, t});
    endtask

    task automatic drive_rx(input logic [3:0] s, input logic [3:0] d, input logic [7:0] ts,
                            input logic [21:0] p, input logic [1:0] t);
        L_valid_in = 1'b1;
        L_data_in = {s, d, ts, p, t};
        if (d == 4'd10) rx_exp.push_back({s, p, t, m_ts - ts});
    endtask

    // Output scoreboards
    always @(negedge clk) begin
        if (L_valid_out) begin
            if (tx_exp.size() == 0) check("tx_extra_flit", 64'(tx_exp.size()), 64'd1);
            else begin
                logic [27:0] e;
                e = tx_exp.pop_front();
                check("tx_flit", 64'(L_data_out), 64'({4'hA, e[27:24], m_ts - 8'd1, e[23:0]}));
            end
        end
        if (rx_valid) begin
            if (rx_exp.size() == 0) check("rx_extra_pulse", 64'(rx_exp.size()), 64'd1);
            else check("rx_fields", 64'({rx_src, rx_payload, rx_type, rx_latency}), 64'(rx_exp.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx_ready", 64'(tx_ready), 64'd1);
        check("rst_l_out", 64'({L_valid_out, L_data_out}), 64'd0);
        check("rst_rx_out", 64'({rx_valid, rx_src, rx_payload, rx_type, rx_latency}), 64'd0);
        check("rst_counters", {tx_count, rx_count, err_count, stall_count}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 300 && m_ts != 8'd5; i++) @(negedge clk);
        check("wait_ts5", 64'(m_ts), 64'd5);
        drive_tx(4'd3, 22'h15A5A, 2'b10);
        @(negedge clk);
        tx_req = 1'b0;
        check("inj_not_early", 64'(L_valid_out), 64'd0);
        @(negedge clk);
        check("inj_valid", 64'(L_valid_out), 64'd1);
        check("inj_data", 64'(L_data_out), 64'({4'hA, 4'h3, 8'h06, 22'h15A5A, 2'b10}));
        check("inj_tx_count", 64'(tx_count), 64'd1);
        @(negedge clk);
        check("inj_one_pulse", 64'(L_valid_out), 64'd0);

        full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_tx(4'(i + 1), 22'(22'h100 + i), 2'(i));
            @(negedge clk);
        end
        check("bp_ready_low", 64'(tx_ready), 64'd0);
        drive_tx(4'hF, 22'h3FFFFF, 2'b11);
        @(negedge clk);
        tx_req = 1'b0;
        repeat (6) @(negedge clk);
        check("bp_stall_count", 64'(stall_count), 64'd10);
        check("bp_valid_low", 64'(L_valid_out), 64'd0);
        check("bp_ready_still_low", 64'(tx_ready), 64'd0);
        check("bp_tx_count_hold", 64'(tx_count), 64'd1);
        full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_drain_valid", 64'(L_valid_out), 64'd1);
        end
        check("bp_ready_back", 64'(tx_ready), 64'd1);
        @(negedge clk);
        check("bp_drain_done", 64'(L_valid_out), 64'd0);
        check("bp_tx_count", 64'(tx_count), 64'd5);
        check("bp_stall_hold", 64'(stall_count), 64'd10);
        check("bp_sb_empty", 64'(tx_exp.size()), 64'd0);

        for (int i = 0; i < 300 && m_ts != 8'h03; i++) @(negedge clk);
        check("wait_ts3", 64'(m_ts), 64'd3);
        drive_rx(4'd7, 4'd10, 8'hFE, 22'h2ABCD, 2'b01);
        @(negedge clk);
        L_valid_in = 1'b0;
        check("rx_valid", 64'(rx_valid), 64'd1);
        check("rx_src", 64'(rx_src), 64'd7);
        check("rx_latency_wrap", 64'(rx_latency), 64'd5);
        check("rx_count", 64'(rx_count), 64'd1);
        @(negedge clk);
        check("rx_one_pulse", 64'(rx_valid), 64'd0);

        drive_rx(4'd2, 4'd4, 8'h11, 22'h0, 2'b00);
        @(negedge clk);
        L_valid_in = 1'b0;
        check("mis_rx_valid", 64'(rx_valid), 64'd0);
        check("mis_err_count", 64'(err_count), 64'd1);
        check("mis_fields_hold", 64'({rx_src, rx_payload, rx_type, rx_latency}),
              64'({4'd7, 22'h2ABCD, 2'b01, 8'd5}));
        check("mis_rx_count", 64'(rx_count), 64'd1);

        full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_tx(4'(i + 8), 22'(22'h3000 + i), 2'b11);
            if (i == 2) drive_rx(4'd5, 4'd10, 8'h40, 22'h11111, 2'b10);
            @(negedge clk);
        end
        tx_req = 1'b0;
        L_valid_in = 1'b0;
        check("mr_rx_pulse", 64'(rx_valid), 64'd1);
        check("mr_ready_before", 64'(tx_ready), 64'd1);
        #2 rst_n = 1'b0;
        tx_exp.delete();
        #1;
        check("mr_tx_ready", 64'(tx_ready), 64'd1);
        check("mr_l_out", 64'({L_valid_out, L_data_out}), 64'd0);
        check("mr_rx_out", 64'({rx_valid, rx_src, rx_payload, rx_type, rx_latency}), 64'd0);
        check("mr_counters", {tx_count, rx_count, err_count, stall_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mr_no_stale_valid", 64'(L_valid_out), 64'd0);
        end
        check("mr_tx_count", 64'(tx_count), 64'd0);

        for (int i = 0; i < 20; i++) begin
            drive_tx(4'($urandom), 22'($urandom), 2'($urandom));
            drive_rx(4'($urandom), 4'd10, 8'($urandom), 22'($urandom), 2'($urandom));
            @(negedge clk);
            check("conc_ready", 64'(tx_ready), 64'd1);
        end
        tx_req = 1'b0;
        L_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check("conc_tx_count", 64'(tx_count), 64'd20);
        check("conc_rx_count", 64'(rx_count), 64'd20);
        check("conc_tx_sb_empty", 64'(tx_exp.size()), 64'd0);
        check("conc_rx_sb_empty", 64'(rx_exp.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
